// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_scoreboard_unit_pkg
//   Shared constants and types for the hazard/scoreboard controller.
//   - FWD_* : EXE operand forwarding select encodings.
//   - *_DEF : default register-address width and MDU latency.
//   - mdu_state_t : MDU tracker state encoding.
package hazard_scoreboard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int REG_AW_DEF  = 5;
    localparam int MDU_LAT_DEF = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_mdu_scoreboard.sv
// hazard_scoreboard_unit_mdu_scoreboard
//   Register scoreboard plus latency tracker for one outstanding MDU op.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   MDU_IDLE | no MDU op in flight; scoreboard empty
//   MDU_BUSY | op in flight; counter runs down, writeback when it is 0
//
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     i_mdu_issue       accept a new MDU op this cycle (never while busy)
//     i_rd              destination of the issuing op
//     i_q_rs/rt/rd      scoreboard query addresses (ID stage)
//     o_rs/rt/rd_pend   queried register has a pending MDU write
//     o_busy            op outstanding (includes the writeback cycle)
//     o_wb_valid        MDU result written this cycle
//     o_wb_rd           captured destination register
module hazard_scoreboard_unit_mdu_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mdu_issue,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_q_rs,
    input  logic [REG_AW-1:0] i_q_rt,
    input  logic [REG_AW-1:0] i_q_rd,
    output logic              o_rs_pend,
    output logic              o_rt_pend,
    output logic              o_rd_pend,
    output logic              o_busy,
    output logic              o_wb_valid,
    output logic [REG_AW-1:0] o_wb_rd
);

    localparam int NREG  = 1 << REG_AW;
    localparam int CNT_W = $clog2(MDU_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);

    mdu_state_t        r_state;
    mdu_state_t        w_state_nxt;
    logic [NREG-1:0]   r_sb;
    logic [CNT_W-1:0]  r_cnt;
    logic [REG_AW-1:0] r_rd;
    logic              w_wb_valid;

    assign w_wb_valid = (r_state == MDU_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_IDLE: if (i_mdu_issue) w_state_nxt = MDU_BUSY;
            MDU_BUSY: if (r_cnt == '0) w_state_nxt = MDU_IDLE;
            default:  w_state_nxt = MDU_IDLE;
        endcase
    end

    // Issue and writeback never share a cycle: the top stalls any MDU op
    // while busy, which includes the writeback cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb  <= '0;
            r_cnt <= '0;
            r_rd  <= '0;
        end else if (i_mdu_issue) begin
            r_cnt <= CNT_INIT;
            r_rd  <= i_rd;
            if (i_rd != '0) r_sb[i_rd] <= 1'b1;
        end else if (r_state == MDU_BUSY) begin
            if (w_wb_valid) begin
                r_sb[r_rd] <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Bit 0 is never set, so register 0 can never report pending.
    assign o_rs_pend  = r_sb[i_q_rs];
    assign o_rt_pend  = r_sb[i_q_rt];
    assign o_rd_pend  = r_sb[i_q_rd];
    assign o_busy     = (r_state == MDU_BUSY);
    assign o_wb_valid = w_wb_valid;
    assign o_wb_rd    = r_rd;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard controller for the 5-stage pipeline: stall/flush control,
//   EXE forwarding selects and the MDU register scoreboard.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN adds saturating
//   performance counters (perf_stall_cnt, perf_flush_cnt,
//   perf_mdu_stall_cnt) and the PERF_CW parameter.
//
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     br_taken_exe                     taken branch/jump resolved in EXE
//     rs_id/rt_id, rs_used_id/rt_used_id  ID sources and use flags
//     rd_id, reg_w_en_id, mdu_op_id    ID destination, write enable, MDU op
//     dm_r_en_exe, rd_exe              EXE load flag and destination
//     rs_exe, rt_exe                   EXE sources for forwarding
//     reg_w_en_mem/rd_mem, reg_w_en_wb/rd_wb  later-stage writers
//     flush*/bubble*                   per-stage controls
//     fwd_a_sel, fwd_b_sel             0 regfile, 1 MEM, 2 WB
//     mdu_busy, mdu_wb_valid, mdu_wb_rd  MDU status / writeback port
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = MDU_LAT_DEF
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_CW = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken_exe,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              reg_w_en_id,
    input  logic              mdu_op_id,
    input  logic              dm_r_en_exe,
    input  logic [REG_AW-1:0] rd_exe,
    input  logic [REG_AW-1:0] rs_exe,
    input  logic [REG_AW-1:0] rt_exe,
    input  logic              reg_w_en_mem,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              reg_w_en_wb,
    input  logic [REG_AW-1:0] rd_wb,
    output logic              flushF,
    output logic              bubbleF,
    output logic              flushD,
    output logic              bubbleD,
    output logic              flushE,
    output logic              bubbleE,
    output logic              flushM,
    output logic              bubbleM,
    output logic              flushW,
    output logic              bubbleW,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mdu_busy,
    output logic              mdu_wb_valid,
    output logic [REG_AW-1:0] mdu_wb_rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CW-1:0] perf_stall_cnt,
    output logic [PERF_CW-1:0] perf_flush_cnt,
    output logic [PERF_CW-1:0] perf_mdu_stall_cnt
`endif
);

    logic w_rs_pend, w_rt_pend, w_rd_pend;
    logic w_load_use, w_sb_raw, w_sb_waw, w_mdu_struct, w_stall;
    logic w_mdu_issue;

    assign w_load_use = dm_r_en_exe && (rd_exe != '0) &&
                        ((rs_used_id && (rs_id == rd_exe)) ||
                         (rt_used_id && (rt_id == rd_exe)));
    assign w_sb_raw     = (rs_used_id && w_rs_pend) || (rt_used_id && w_rt_pend);
    assign w_sb_waw     = (reg_w_en_id || mdu_op_id) && (rd_id != '0) && w_rd_pend;
    assign w_mdu_struct = mdu_op_id && mdu_busy;
    assign w_stall      = w_load_use || w_sb_raw || w_sb_waw || w_mdu_struct;

    // A flushed ID instruction must not start an MDU op; one already in
    // flight is older than the branch and keeps running.
    assign w_mdu_issue = mdu_op_id && !w_stall && !br_taken_exe;

    hazard_scoreboard_unit_mdu_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_LAT (MDU_LAT)
    ) u_mdu_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mdu_issue (w_mdu_issue),
        .i_rd        (rd_id),
        .i_q_rs      (rs_id),
        .i_q_rt      (rt_id),
        .i_q_rd      (rd_id),
        .o_rs_pend   (w_rs_pend),
        .o_rt_pend   (w_rt_pend),
        .o_rd_pend   (w_rd_pend),
        .o_busy      (mdu_busy),
        .o_wb_valid  (mdu_wb_valid),
        .o_wb_rd     (mdu_wb_rd)
    );

    always_comb begin
        flushF  = 1'b0;
        bubbleF = 1'b0;
        flushD  = 1'b0;
        bubbleD = 1'b0;
        flushE  = 1'b0;
        bubbleE = 1'b0;
        flushM  = 1'b0;
        bubbleM = 1'b0;
        flushW  = 1'b0;
        bubbleW = 1'b0;
        if (br_taken_exe) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_stall) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end
    end

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a_sel = FWD_RF;
        if (reg_w_en_mem && (rd_mem != '0) && (rd_mem == rs_exe)) begin
            fwd_a_sel = FWD_MEM;
        end else if (reg_w_en_wb && (rd_wb != '0) && (rd_wb == rs_exe)) begin
            fwd_a_sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_b_sel = FWD_RF;
        if (reg_w_en_mem && (rd_mem != '0) && (rd_mem == rt_exe)) begin
            fwd_b_sel = FWD_MEM;
        end else if (reg_w_en_wb && (rd_wb != '0) && (rd_wb == rt_exe)) begin
            fwd_b_sel = FWD_WB;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic r_dummy_unused;
    logic [PERF_CW-1:0] r_perf_stall, r_perf_flush, r_perf_mdu;
    logic w_mdu_stall;

    assign w_mdu_stall = w_sb_raw || w_sb_waw || w_mdu_struct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_mdu   <= '0;
        end else begin
            if (w_stall && !br_taken_exe && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + PERF_CW'(1);
            if (br_taken_exe && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + PERF_CW'(1);
            if (w_mdu_stall && !br_taken_exe && (r_perf_mdu != '1))
                r_perf_mdu <= r_perf_mdu + PERF_CW'(1);
        end
    end

    assign perf_stall_cnt     = r_perf_stall;
    assign perf_flush_cnt     = r_perf_flush;
    assign perf_mdu_stall_cnt = r_perf_mdu;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit
//   Directed bench for hazard_scoreboard_unit (default parameters:
//   REG_AW=5, MDU_LAT=4). Inputs are driven at the falling edge and
//   outputs sampled 1 time unit later, away from the rising edge.
module tb_hazard_scoreboard_unit;

    localparam int AW = 5;

    // {flushF,bubbleF,flushD,bubbleD,flushE,bubbleE,flushM,bubbleM,flushW,bubbleW}
    localparam logic [9:0] CTL_NONE  = 10'b00_00_00_0000;
    localparam logic [9:0] CTL_STALL = 10'b01_01_10_0000;
    localparam logic [9:0] CTL_BR    = 10'b00_10_10_0000;

    logic          clk;
    logic          rst_n;
    logic          br_taken_exe;
    logic [AW-1:0] rs_id, rt_id, rd_id;
    logic          rs_used_id, rt_used_id, reg_w_en_id, mdu_op_id;
    logic          dm_r_en_exe;
    logic [AW-1:0] rd_exe, rs_exe, rt_exe;
    logic          reg_w_en_mem, reg_w_en_wb;
    logic [AW-1:0] rd_mem, rd_wb;
    logic          flushF, bubbleF, flushD, bubbleD, flushE, bubbleE;
    logic          flushM, bubbleM, flushW, bubbleW;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          mdu_busy, mdu_wb_valid;
    logic [AW-1:0] mdu_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt, perf_mdu_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken_exe (br_taken_exe),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .rs_used_id   (rs_used_id),
        .rt_used_id   (rt_used_id),
        .rd_id        (rd_id),
        .reg_w_en_id  (reg_w_en_id),
        .mdu_op_id    (mdu_op_id),
        .dm_r_en_exe  (dm_r_en_exe),
        .rd_exe       (rd_exe),
        .rs_exe       (rs_exe),
        .rt_exe       (rt_exe),
        .reg_w_en_mem (reg_w_en_mem),
        .rd_mem       (rd_mem),
        .reg_w_en_wb  (reg_w_en_wb),
        .rd_wb        (rd_wb),
        .flushF       (flushF),
        .bubbleF      (bubbleF),
        .flushD       (flushD),
        .bubbleD      (bubbleD),
        .flushE       (flushE),
        .bubbleE      (bubbleE),
        .flushM       (flushM),
        .bubbleM      (bubbleM),
        .flushW       (flushW),
        .bubbleW      (bubbleW),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mdu_busy     (mdu_busy),
        .mdu_wb_valid (mdu_wb_valid),
        .mdu_wb_rd    (mdu_wb_rd)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt     (perf_stall_cnt),
        .perf_flush_cnt     (perf_flush_cnt),
        .perf_mdu_stall_cnt (perf_mdu_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctl();
        return {flushF, bubbleF, flushD, bubbleD, flushE, bubbleE,
                flushM, bubbleM, flushW, bubbleW};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        br_taken_exe = 1'b0;
        rs_id = '0; rt_id = '0; rd_id = '0;
        rs_used_id = 1'b0; rt_used_id = 1'b0;
        reg_w_en_id = 1'b0; mdu_op_id = 1'b0;
        dm_r_en_exe = 1'b0; rd_exe = '0; rs_exe = '0; rt_exe = '0;
        reg_w_en_mem = 1'b0; rd_mem = '0;
        reg_w_en_wb = 1'b0; rd_wb = '0;
    endtask

    // Advance to the next falling edge and return all inputs to idle.
    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    initial begin
        // Reset state; a consumer of r8 must not stall on an empty scoreboard.
        rst_n = 1'b0;
        idle();
        rs_id = 5'd8; rs_used_id = 1'b1;
        #2;
        chk("rst_busy", 32'(mdu_busy), 32'd0);
        chk("rst_wb_valid", 32'(mdu_wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(mdu_wb_rd), 32'd0);
        chk("rst_ctl", 32'(ctl()), 32'(CTL_NONE));
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs, then released the next cycle.
        tick();
        dm_r_en_exe = 1'b1; rd_exe = 5'd5; rs_id = 5'd5; rs_used_id = 1'b1;
        #1 chk("lu_rs", 32'(ctl()), 32'(CTL_STALL));
        tick();
        #1 chk("lu_released", 32'(ctl()), 32'(CTL_NONE));
        tick();
        dm_r_en_exe = 1'b1; rd_exe = 5'd5; rt_id = 5'd5; rt_used_id = 1'b1; rs_id = 5'd5;
        #1 chk("lu_rt", 32'(ctl()), 32'(CTL_STALL));
        tick();
        dm_r_en_exe = 1'b1; rd_exe = 5'd5; rs_id = 5'd5; rt_id = 5'd5;
        #1 chk("lu_unused", 32'(ctl()), 32'(CTL_NONE));
        tick();
        dm_r_en_exe = 1'b1; rd_exe = 5'd0; rs_id = 5'd0; rs_used_id = 1'b1;
        #1 chk("lu_r0", 32'(ctl()), 32'(CTL_NONE));

        // Branch beats a load-use stall and blocks MDU issue.
        tick();
        br_taken_exe = 1'b1;
        dm_r_en_exe = 1'b1; rd_exe = 5'd5; rs_id = 5'd5; rs_used_id = 1'b1;
        mdu_op_id = 1'b1; rd_id = 5'd7;
        #1 chk("br_ctl", 32'(ctl()), 32'(CTL_BR));
        tick();
        #1 chk("br_no_issue", 32'(mdu_busy), 32'd0);

        // MDU RAW: issue rd 8 at t, consumer of r8 stalls t+1..t+4.
        tick();
        mdu_op_id = 1'b1; rd_id = 5'd8;
        #1 chk("raw_issue_ctl", 32'(ctl()), 32'(CTL_NONE));
        chk("raw_issue_busy", 32'(mdu_busy), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            rs_id = 5'd8; rs_used_id = 1'b1;
            #1 chk($sformatf("raw_stall_t%0d", k), 32'(ctl()), 32'(CTL_STALL));
            chk($sformatf("raw_busy_t%0d", k), 32'(mdu_busy), 32'd1);
            chk($sformatf("raw_wbv_t%0d", k), 32'(mdu_wb_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("raw_wb_rd", 32'(mdu_wb_rd), 32'd8);
        tick();
        rs_id = 5'd8; rs_used_id = 1'b1;
        #1 chk("raw_t5_ctl", 32'(ctl()), 32'(CTL_NONE));
        chk("raw_t5_busy", 32'(mdu_busy), 32'd0);
        chk("raw_t5_wbv", 32'(mdu_wb_valid), 32'd0);

        // WAW and structural hazards against a pending rd 8.
        tick();
        mdu_op_id = 1'b1; rd_id = 5'd8;
        #1 chk("waw_issue_ctl", 32'(ctl()), 32'(CTL_NONE));
        tick();
        rd_id = 5'd8; reg_w_en_id = 1'b1;
        #1 chk("waw_stall", 32'(ctl()), 32'(CTL_STALL));
        for (int k = 2; k <= 4; k++) begin
            tick();
            mdu_op_id = 1'b1; rd_id = 5'd9;
            #1 chk($sformatf("struct_stall_u%0d", k), 32'(ctl()), 32'(CTL_STALL));
        end
        chk("struct_wbv_u4", 32'(mdu_wb_valid), 32'd1);
        tick();
        mdu_op_id = 1'b1; rd_id = 5'd9;
        #1 chk("struct_issue_ctl", 32'(ctl()), 32'(CTL_NONE));
        chk("struct_issue_busy", 32'(mdu_busy), 32'd0);
        // In-flight op survives a taken branch; writeback 4 cycles after issue.
        tick();
        br_taken_exe = 1'b1;
        #1 chk("inflight_br_ctl", 32'(ctl()), 32'(CTL_BR));
        chk("inflight_br_busy", 32'(mdu_busy), 32'd1);
        tick();
        #1 chk("inflight_busy_u7", 32'(mdu_busy), 32'd1);
        tick();
        #1 chk("inflight_wbv_u8", 32'(mdu_wb_valid), 32'd0);
        tick();
        #1 chk("inflight_wbv_u9", 32'(mdu_wb_valid), 32'd1);
        chk("inflight_wb_rd", 32'(mdu_wb_rd), 32'd9);
        tick();
        #1 chk("inflight_done", 32'(mdu_busy), 32'd0);

        // Forwarding priority and register-0 exclusion.
        tick();
        reg_w_en_mem = 1'b1; rd_mem = 5'd3; reg_w_en_wb = 1'b1; rd_wb = 5'd3;
        rs_exe = 5'd3; rt_exe = 5'd0;
        #1 chk("fwd_a_mem", 32'(fwd_a_sel), 32'd1);
        chk("fwd_b_r0", 32'(fwd_b_sel), 32'd0);
        tick();
        reg_w_en_mem = 1'b1; rd_mem = 5'd0; reg_w_en_wb = 1'b1; rd_wb = 5'd3;
        rs_exe = 5'd3; rt_exe = 5'd3;
        #1 chk("fwd_a_wb", 32'(fwd_a_sel), 32'd2);
        chk("fwd_b_wb", 32'(fwd_b_sel), 32'd2);
        tick();
        reg_w_en_mem = 1'b0; rd_mem = 5'd4; reg_w_en_wb = 1'b1; rd_wb = 5'd6;
        rs_exe = 5'd4; rt_exe = 5'd6;
        #1 chk("fwd_a_nowen", 32'(fwd_a_sel), 32'd0);
        chk("fwd_b_wb2", 32'(fwd_b_sel), 32'd2);

        // Reset two cycles into an MDU op abandons it.
        tick();
        mdu_op_id = 1'b1; rd_id = 5'd8;
        #1 chk("rmid_issue_ctl", 32'(ctl()), 32'(CTL_NONE));
        tick();
        #1 chk("rmid_busy", 32'(mdu_busy), 32'd1);
        tick();
        rst_n = 1'b0;
        rs_id = 5'd8; rs_used_id = 1'b1;
        #1 chk("rmid_rst_busy", 32'(mdu_busy), 32'd0);
        chk("rmid_rst_ctl", 32'(ctl()), 32'(CTL_NONE));
        chk("rmid_rst_wb_rd", 32'(mdu_wb_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            if (k > 3) tick();
            rs_id = 5'd8; rs_used_id = 1'b1;
            #1 chk($sformatf("rmid_wbv_t%0d", k), 32'(mdu_wb_valid), 32'd0);
            chk($sformatf("rmid_ctl_t%0d", k), 32'(ctl()), 32'(CTL_NONE));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
